// File: rtl/fp_add_scheduler_if.sv
// Operand, adder and result bundle for fp_add_scheduler.
// Defining FP_SCHED_STATS_EN adds the statistics counters to the bundle.
interface fp_add_scheduler_if;
  logic        a_valid;
  logic        a_ready;
  logic [31:0] a_op1;
  logic [31:0] a_op2;
  logic        a_sub;
  logic        b_valid;
  logic        b_ready;
  logic [31:0] b_op1;
  logic [31:0] b_op2;
  logic        b_sub;
  logic        fpu_valid;
  logic [31:0] fpu_op1;
  logic [31:0] fpu_op2;
  logic [31:0] fpu_res;
  logic        a_res_valid;
  logic        a_res_ready;
  logic [31:0] a_res_data;
  logic        b_res_valid;
  logic        b_res_ready;
  logic [31:0] b_res_data;
  logic        busy;
`ifdef FP_SCHED_STATS_EN
  logic [15:0] stat_a_ops;
  logic [15:0] stat_b_ops;
  logic [15:0] stat_stall;
`endif

  modport slave (
    input  a_valid, a_op1, a_op2, a_sub, b_valid, b_op1, b_op2, b_sub,
    input  fpu_res, a_res_ready, b_res_ready,
    output a_ready, b_ready, fpu_valid, fpu_op1, fpu_op2,
    output a_res_valid, a_res_data, b_res_valid, b_res_data,
    output busy
`ifdef FP_SCHED_STATS_EN
    , output stat_a_ops, stat_b_ops, stat_stall
`endif
  );

  modport master (
    output a_valid, a_op1, a_op2, a_sub, b_valid, b_op1, b_op2, b_sub,
    output fpu_res, a_res_ready, b_res_ready,
    input  a_ready, b_ready, fpu_valid, fpu_op1, fpu_op2,
    input  a_res_valid, a_res_data, b_res_valid, b_res_data,
    input  busy
`ifdef FP_SCHED_STATS_EN
    , input stat_a_ops, stat_b_ops, stat_stall
`endif
  );
endinterface

// File: rtl/fp_add_scheduler.sv
// Shares one pipelined FP adder between two requesters with round-robin, credits and result FIFOs.
// Define FP_SCHED_STATS_EN to add saturating grant/stall counters.
module fp_add_scheduler #(
  parameter int LATENCY    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  fp_add_scheduler_if.slave sched
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(FIFO_DEPTH);

  // Index 0 is requester A, index 1 is requester B.
  logic [1:0]       w_valid;
  logic [1:0][31:0] w_op1;
  logic [1:0][31:0] w_op2;
  logic [1:0]       w_sub;
  logic [1:0]       w_res_ready;
  logic [1:0]       w_elig;
  logic [1:0]       w_grant;
  logic [1:0]       w_pop;
  logic [1:0]       w_push;
  logic [1:0]       w_nonempty;
  logic [1:0][31:0] w_head;

  logic               r_rr_last;
  logic               r_fpu_valid;
  logic [31:0]        r_fpu_op1;
  logic [31:0]        r_fpu_op2;
  logic               r_issue_id;
  logic [LATENCY-1:0] r_tag_valid;
  logic [LATENCY-1:0] r_tag_id;

  assign w_valid     = {sched.b_valid, sched.a_valid};
  assign w_op1       = {sched.b_op1, sched.a_op1};
  assign w_op2       = {sched.b_op2, sched.a_op2};
  assign w_sub       = {sched.b_sub, sched.a_sub};
  assign w_res_ready = {sched.b_res_ready, sched.a_res_ready};

  // On a tie, the requester not granted last wins.
  always_comb begin
    w_grant = w_elig;
    if (w_elig == 2'b11) begin
      w_grant = r_rr_last ? 2'b01 : 2'b10;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      logic [CW-1:0] r_credit;
      logic [PW:0]   r_wr_ptr;
      logic [PW:0]   r_rd_ptr;
      logic [31:0]   r_mem [FIFO_DEPTH];

      assign w_elig[gi]     = w_valid[gi] & (r_credit != '0);
      assign w_nonempty[gi] = (r_wr_ptr != r_rd_ptr);
      assign w_pop[gi]      = w_nonempty[gi] & w_res_ready[gi];
      assign w_push[gi]     = r_tag_valid[LATENCY-1] & (r_tag_id[LATENCY-1] == 1'(gi));
      assign w_head[gi]     = w_nonempty[gi] ? r_mem[r_rd_ptr[PW-1:0]] : 32'd0;

      // Credits cover both FIFO occupancy and results still inside the adder.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_credit <= CREDIT_MAX;
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
        end else begin
          case ({w_grant[gi], w_pop[gi]})
            2'b10:   r_credit <= r_credit - 1'b1;
            2'b01:   r_credit <= r_credit + 1'b1;
            default: r_credit <= r_credit;
          endcase
          if (w_push[gi]) r_wr_ptr <= r_wr_ptr + 1'b1;
          if (w_pop[gi])  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (w_push[gi]) r_mem[r_wr_ptr[PW-1:0]] <= sched.fpu_res;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_last   <= 1'b1;
      r_fpu_valid <= 1'b0;
      r_fpu_op1   <= '0;
      r_fpu_op2   <= '0;
      r_issue_id  <= 1'b0;
      r_tag_valid <= '0;
      r_tag_id    <= '0;
    end else begin
      r_fpu_valid <= |w_grant;
      if (|w_grant) begin
        r_rr_last  <= w_grant[1];
        r_issue_id <= w_grant[1];
        r_fpu_op1  <= w_op1[w_grant[1]];
        r_fpu_op2  <= {w_op2[w_grant[1]][31] ^ w_sub[w_grant[1]], w_op2[w_grant[1]][30:0]};
      end
      r_tag_valid[0] <= r_fpu_valid;
      r_tag_id[0]    <= r_issue_id;
      for (int k = LATENCY - 1; k > 0; k--) begin
        r_tag_valid[k] <= r_tag_valid[k-1];
        r_tag_id[k]    <= r_tag_id[k-1];
      end
    end
  end

  // Ready is masked while reset is asserted so every output reads 0.
  assign sched.a_ready     = w_grant[0] & rst_n;
  assign sched.b_ready     = w_grant[1] & rst_n;
  assign sched.fpu_valid   = r_fpu_valid;
  assign sched.fpu_op1     = r_fpu_op1;
  assign sched.fpu_op2     = r_fpu_op2;
  assign sched.a_res_valid = w_nonempty[0];
  assign sched.a_res_data  = w_head[0];
  assign sched.b_res_valid = w_nonempty[1];
  assign sched.b_res_data  = w_head[1];
  assign sched.busy        = (|r_tag_valid) | (|w_nonempty) | r_fpu_valid;

`ifdef FP_SCHED_STATS_EN
  logic [15:0] r_stat_a_ops;
  logic [15:0] r_stat_b_ops;
  logic [15:0] r_stat_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_a_ops <= '0;
      r_stat_b_ops <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_grant[0] && r_stat_a_ops != 16'hFFFF) r_stat_a_ops <= r_stat_a_ops + 16'd1;
      if (w_grant[1] && r_stat_b_ops != 16'hFFFF) r_stat_b_ops <= r_stat_b_ops + 16'd1;
      if ((|(w_valid & ~w_elig)) && r_stat_stall != 16'hFFFF) r_stat_stall <= r_stat_stall + 16'd1;
    end
  end

  assign sched.stat_a_ops = r_stat_a_ops;
  assign sched.stat_b_ops = r_stat_b_ops;
  assign sched.stat_stall = r_stat_stall;
`else
  // No statistics hardware in this build.
`endif
endmodule

// File: tb/tb_fp_add_scheduler.sv
// Scoreboard bench for fp_add_scheduler with a behavioural fixed-latency adder.
// Define FP_SCHED_STATS_EN to also check the statistics counters.
module tb_fp_add_scheduler;
  localparam int LAT   = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int pops_a = 0;
  int pops_b = 0;
  logic [31:0] exp_a [$];
  logic [31:0] exp_b [$];
  logic [31:0] adder_pipe [LAT];

  fp_add_scheduler_if bus();

  fp_add_scheduler #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sched (bus)
  );

  always #5 clk = ~clk;

  // Stand-in adder: exact for the directed vectors, a fixed scramble otherwise.
  function automatic logic [31:0] bench_add(input logic [31:0] x, input logic [31:0] y);
    if (x == 32'h3F800000 && y == 32'h40000000) return 32'h40400000;
    if (x == 32'h40400000 && y == 32'hBF800000) return 32'h40000000;
    return (x + y) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] exp_result(input logic [31:0] op1, input logic [31:0] op2, input logic sub);
    logic [31:0] eff;
    eff = op2;
    if (sub) eff[31] = ~op2[31];
    return bench_add(op1, eff);
  endfunction

  always @(posedge clk) begin
    adder_pipe[0] <= bus.fpu_valid ? bench_add(bus.fpu_op1, bus.fpu_op2) : 32'hDEAD0000;
    for (int k = 1; k < LAT; k++) adder_pipe[k] <= adder_pipe[k-1];
  end
  assign bus.fpu_res = adder_pipe[LAT-1];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Scoreboard: push on operand handshake, pop on result handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.a_valid && bus.a_ready) exp_a.push_back(exp_result(bus.a_op1, bus.a_op2, bus.a_sub));
      if (bus.b_valid && bus.b_ready) exp_b.push_back(exp_result(bus.b_op1, bus.b_op2, bus.b_sub));
      if (bus.a_res_valid && bus.a_res_ready) begin
        if (exp_a.size() == 0) check_val("a_unexpected", {31'd0, bus.a_res_valid}, 32'd0);
        else begin
          check_val("a_res", bus.a_res_data, exp_a.pop_front());
          pops_a++;
        end
        $display("res A data=%h", bus.a_res_data);
      end
      if (bus.b_res_valid && bus.b_res_ready) begin
        if (exp_b.size() == 0) check_val("b_unexpected", {31'd0, bus.b_res_valid}, 32'd0);
        else begin
          check_val("b_res", bus.b_res_data, exp_b.pop_front());
          pops_b++;
        end
        $display("res B data=%h", bus.b_res_data);
      end
    end
  end

  task automatic new_a();
    bus.a_op1 = $urandom;
    bus.a_op2 = $urandom;
    bus.a_sub = 1'($urandom_range(0, 1));
  endtask

  task automatic new_b();
    bus.b_op1 = $urandom;
    bus.b_op2 = $urandom;
    bus.b_sub = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    bus.a_res_ready = 1'b1;
    bus.b_res_ready = 1'b1;
    rst_n = 1'b0;
    exp_a.delete();
    exp_b.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((bus.busy || exp_a.size() != 0 || exp_b.size() != 0) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(negedge clk);
    check_val({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
    check_val({tag, "_sb_left"}, 32'(exp_a.size() + exp_b.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int saved;
    logic ga, gb, hs;
    bus.a_op1 = '0; bus.a_op2 = '0; bus.a_sub = 1'b0;
    bus.b_op1 = '0; bus.b_op2 = '0; bus.b_sub = 1'b0;

    // Reset state
    do_reset();
    @(negedge clk);
    check_val("rst_a_ready", {31'd0, bus.a_ready}, 32'd0);
    check_val("rst_fpu_valid", {31'd0, bus.fpu_valid}, 32'd0);
    check_val("rst_fpu_op1", bus.fpu_op1, 32'd0);
    check_val("rst_a_res_valid", {31'd0, bus.a_res_valid}, 32'd0);
    check_val("rst_b_res_valid", {31'd0, bus.b_res_valid}, 32'd0);
    check_val("rst_busy", {31'd0, bus.busy}, 32'd0);
`ifdef FP_SCHED_STATS_EN
    check_val("rst_stat_a", 32'(bus.stat_a_ops), 32'd0);
    check_val("rst_stat_stall", 32'(bus.stat_stall), 32'd0);
`endif

    // Single add on A, with latency checks
    @(posedge clk); #1;
    bus.a_op1 = 32'h3F800000; bus.a_op2 = 32'h40000000; bus.a_sub = 1'b0; bus.a_valid = 1'b1;
    @(negedge clk);
    check_val("add_a_ready", {31'd0, bus.a_ready}, 32'd1);
    @(posedge clk); #1;
    bus.a_valid = 1'b0;
    @(negedge clk);
    check_val("add_fpu_valid", {31'd0, bus.fpu_valid}, 32'd1);
    check_val("add_fpu_op1", bus.fpu_op1, 32'h3F800000);
    check_val("add_fpu_op2", bus.fpu_op2, 32'h40000000);
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    check_val("add_early_valid", {31'd0, bus.a_res_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_val("add_res_valid", {31'd0, bus.a_res_valid}, 32'd1);
    check_val("add_res_data", bus.a_res_data, 32'h40400000);
    check_val("add_b_quiet", {31'd0, bus.b_res_valid}, 32'd0);
    $display("txn add A done");
    wait_idle("add");

    // Subtract on B
    @(posedge clk); #1;
    bus.b_op1 = 32'h40400000; bus.b_op2 = 32'h3F800000; bus.b_sub = 1'b1; bus.b_valid = 1'b1;
    @(posedge clk); #1;
    bus.b_valid = 1'b0;
    @(negedge clk);
    check_val("sub_fpu_op2", bus.fpu_op2, 32'hBF800000);
    repeat (LAT + 1) @(posedge clk);
    @(negedge clk);
    check_val("sub_b_res_valid", {31'd0, bus.b_res_valid}, 32'd1);
    check_val("sub_b_res_data", bus.b_res_data, 32'h40000000);
    check_val("sub_a_quiet", {31'd0, bus.a_res_valid}, 32'd0);
    $display("txn sub B done");
    wait_idle("sub");

    // Contention: alternate grants starting with A
    do_reset();
    new_a(); new_b();
    bus.a_valid = 1'b1; bus.b_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ga = bus.a_ready; gb = bus.b_ready;
      check_val("rr_grant", {30'd0, ga, gb}, (i % 2 == 0) ? 32'd2 : 32'd1);
      $display("txn rr cycle=%0d a_ready=%0b b_ready=%0b", i, ga, gb);
      @(posedge clk); #1;
      if (ga) new_a();
      if (gb) new_b();
    end
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    wait_idle("rr");

    // Backpressure: only DEPTH ops accepted while A's results are not drained
    do_reset();
    saved = pops_a;
    bus.a_res_ready = 1'b0;
    sent = 0;
    new_a();
    bus.a_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      hs = bus.a_valid && bus.a_ready;
      if (hs) sent++;
      @(posedge clk); #1;
      if (hs) new_a();
    end
    @(negedge clk);
    check_val("bp_accepted", 32'(sent), 32'(DEPTH));
    check_val("bp_a_ready", {31'd0, bus.a_ready}, 32'd0);
    check_val("bp_fifo_full_valid", {31'd0, bus.a_res_valid}, 32'd1);
    $display("txn backpressure accepted=%0d", sent);
    @(posedge clk); #1;
    bus.a_res_ready = 1'b1;
    for (int c = 0; c < 300 && sent < 10; c++) begin
      @(negedge clk);
      hs = bus.a_valid && bus.a_ready;
      if (hs) sent++;
      @(posedge clk); #1;
      if (hs) new_a();
    end
    bus.a_valid = 1'b0;
    wait_idle("bp");
    check_val("bp_total_sent", 32'(sent), 32'd10);
    check_val("bp_results", 32'(pops_a - saved), 32'd10);
`ifdef FP_SCHED_STATS_EN
    check_val("stat_a_ops", 32'(bus.stat_a_ops), 32'd10);
    check_val("stat_stall_nz", {31'd0, bus.stat_stall != 16'd0}, 32'd1);
`endif

    // Reset with three operations in flight
    do_reset();
    new_a();
    bus.a_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      new_a();
    end
    rst_n = 1'b0;
    #1;
    check_val("mid_a_ready", {31'd0, bus.a_ready}, 32'd0);
    check_val("mid_fpu_valid", {31'd0, bus.fpu_valid}, 32'd0);
    check_val("mid_busy", {31'd0, bus.busy}, 32'd0);
    check_val("mid_a_res_valid", {31'd0, bus.a_res_valid}, 32'd0);
    bus.a_valid = 1'b0;
    exp_a.delete();
    exp_b.delete();
    saved = pops_a;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (LAT + 6) @(posedge clk);
    @(negedge clk);
    check_val("mid_after_busy", {31'd0, bus.busy}, 32'd0);
    check_val("mid_after_valid", {31'd0, bus.a_res_valid}, 32'd0);
    check_val("mid_no_stale", 32'(pops_a), 32'(saved));
    $display("txn reset midflight done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
